// File: rtl/wb_slave_mem_if.sv
// Wishbone classic-cycle bus bundle between one master and one slave.
//   ADR   : byte address              (master -> slave)
//   DAT_W : write data                (master -> slave)
//   DAT_R : read data                 (slave -> master)
//   CYC   : bus cycle active          (master -> slave)
//   STB   : strobe                    (master -> slave)
//   WE    : 1 = write, 0 = read       (master -> slave)
//   SEL   : byte-lane enables         (master -> slave)
//   ACK   : normal termination        (slave -> master)
//   ERR   : error termination         (slave -> master)
interface wb_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   ADR;
  logic [DATA_WIDTH-1:0]   DAT_W;
  logic [DATA_WIDTH-1:0]   DAT_R;
  logic                    CYC;
  logic                    STB;
  logic                    WE;
  logic [DATA_WIDTH/8-1:0] SEL;
  logic                    ACK;
  logic                    ERR;

  modport master (
    output ADR, DAT_W, CYC, STB, WE, SEL,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, DAT_W, CYC, STB, WE, SEL,
    output DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_slave_mem.sv
// Wishbone classic-cycle slave backed by a small register-file memory.
// Requests are latched on acceptance, optionally delayed by WAIT_STATES cycles,
// then answered with a one-cycle registered ACK (in window) or ERR (out of window).
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : Wishbone slave modport (ADR, DAT_W, DAT_R, CYC, STB, WE, SEL, ACK, ERR)
module wb_slave_mem #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [31:0]           RESET_DATA  = 32'hdeadbeef,
  parameter logic [31:0]           ERR_DATA    = 32'hbadc0de0
) (
  input logic           clk,
  input logic           rst,
  wb_slave_mem_if.slave bus
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = $clog2(DEPTH);

  localparam logic [DATA_WIDTH-1:0] RstWord = DATA_WIDTH'(RESET_DATA);
  localparam logic [DATA_WIDTH-1:0] ErrWord = DATA_WIDTH'(ERR_DATA);

  // One extra bit so the window top never wraps at the end of the address space.
  localparam logic [ADDR_WIDTH:0] WinLo = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WinHi = WinLo + (ADDR_WIDTH + 1)'(DEPTH * NumBytes);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  we_q, we_d;
  logic [NumBytes-1:0]   sel_q, sel_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  in_range_q, in_range_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic [ADDR_WIDTH:0]   adr_ext;
  logic                  req_in_range;
  logic [DATA_WIDTH-1:0] rdata;

  assign adr_ext      = {1'b0, bus.ADR};
  assign req_in_range = (adr_ext >= WinLo) && (adr_ext < WinHi);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    we_d       = we_q;
    sel_d      = sel_q;
    dat_d      = dat_q;
    in_range_d = in_range_q;
    mem_d      = mem_q;

    unique case (state_q)
      StIdle: begin
        if (bus.CYC && bus.STB) begin
          idx_d      = bus.ADR[OffW +: IdxW];
          we_d       = bus.WE;
          sel_d      = bus.SEL;
          dat_d      = bus.DAT_W;
          in_range_d = req_in_range;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!bus.CYC) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        // Commit happens on the edge that ends RESP, even if CYC has dropped.
        state_d = StIdle;
        if (in_range_q && we_q) begin
          for (int unsigned b = 0; b < NumBytes; b++) begin
            if (sel_q[b]) begin
              mem_d[idx_q][b*8 +: 8] = dat_q[b*8 +: 8];
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      dat_q      <= '0;
      in_range_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RstWord;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      dat_q      <= dat_d;
      in_range_q <= in_range_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read data only during RESP; writes return zero, errors return the marker word.
  always_comb begin
    rdata = '0;
    if (state_q == StResp) begin
      if (!in_range_q) begin
        rdata = ErrWord;
      end else if (!we_q) begin
        rdata = mem_q[idx_q];
      end
    end
  end

  assign bus.DAT_R = rdata;
  assign bus.ACK   = (state_q == StResp) && in_range_q;
  assign bus.ERR   = (state_q == StResp) && !in_range_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Bench for wb_slave_mem: five instances with different window/wait-state settings.
// Stimulus pushes expected responses (data, ACK/ERR, arrival cycle) into a queue;
// a negedge monitor pops and compares whenever a DUT terminates a cycle.
module tb_wb_slave_mem;

  localparam int NDut = 5;
  localparam int WS [NDut] = '{0, 3, 0, 4, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic        cyc_a [NDut];
  logic        stb_a [NDut];
  logic        we_a  [NDut];
  logic [31:0] adr_a [NDut];
  logic [31:0] dw_a  [NDut];
  logic [3:0]  sel_a [NDut];
  logic        ack_a [NDut];
  logic        err_a [NDut];
  logic [31:0] dr_a  [NDut];

  wb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus [NDut] ();

  for (genvar g = 0; g < NDut; g++) begin : g_conn
    assign bus[g].ADR   = adr_a[g];
    assign bus[g].DAT_W = dw_a[g];
    assign bus[g].CYC   = cyc_a[g];
    assign bus[g].STB   = stb_a[g];
    assign bus[g].WE    = we_a[g];
    assign bus[g].SEL   = sel_a[g];
    assign ack_a[g]     = bus[g].ACK;
    assign err_a[g]     = bus[g].ERR;
    assign dr_a[g]      = bus[g].DAT_R;
  end

  wb_slave_mem #(.BASE_ADDR(32'h0), .WAIT_STATES(0)) u_d0 (
    .clk(clk), .rst(rst), .bus(bus[0]));
  wb_slave_mem #(.BASE_ADDR(32'h0), .WAIT_STATES(3)) u_d1 (
    .clk(clk), .rst(rst), .bus(bus[1]));
  wb_slave_mem #(.BASE_ADDR(32'h100), .WAIT_STATES(0)) u_d2 (
    .clk(clk), .rst(rst), .bus(bus[2]));
  wb_slave_mem #(.BASE_ADDR(32'h100), .WAIT_STATES(4)) u_d3 (
    .clk(clk), .rst(rst), .bus(bus[3]));
  wb_slave_mem #(.BASE_ADDR(32'h0), .WAIT_STATES(2)) u_d4 (
    .clk(clk), .rst(rst), .bus(bus[4]));

  typedef struct {
    int          k;
    bit          err;
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  int   found;
  exp_t e;

  // Monitor: every terminated cycle must match the oldest expectation for that DUT.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < NDut; k++) begin
        if (ack_a[k] || err_a[k]) begin
          found = -1;
          for (int j = 0; j < sb.size(); j++) begin
            if (found < 0 && sb[j].k == k) found = j;
          end
          total++;
          if (found < 0) begin
            bad++;
            $display("FAIL unexpected_resp dut%0d: got ack=%0b err=%0b dat=%h cyc=%0d, want none",
                     k, ack_a[k], err_a[k], dr_a[k], cyc_cnt);
          end else begin
            e = sb[found];
            sb.delete(found);
            if (ack_a[k] !== !e.err || err_a[k] !== e.err || dr_a[k] !== e.data ||
                cyc_cnt != e.due) begin
              bad++;
              $display("FAIL %s: got ack=%0b err=%0b dat=%h cyc=%0d, want ack=%0b err=%0b dat=%h cyc=%0d",
                       e.name, ack_a[k], err_a[k], dr_a[k], cyc_cnt,
                       !e.err, e.err, e.data, e.due);
            end
          end
        end else begin
          total++;
          if (dr_a[k] !== 32'h0) begin
            bad++;
            $display("FAIL idle_datr dut%0d: got %h, want 00000000", k, dr_a[k]);
          end
        end
      end
    end
  end

  task automatic push(input int k, input bit er, input logic [31:0] d, input int due,
                      input string nm);
    exp_t x;
    x.k = k; x.err = er; x.data = d; x.due = due; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic drive(input int k, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s);
    adr_a[k] = a; we_a[k] = w; dw_a[k] = d; sel_a[k] = s;
    cyc_a[k] = 1'b1; stb_a[k] = 1'b1;
  endtask

  task automatic release_bus(input int k);
    cyc_a[k] = 1'b0; stb_a[k] = 1'b0; we_a[k] = 1'b0;
  endtask

  // Single classic cycle: hold CYC/STB until ACK/ERR, then drop.
  task automatic xfer(input int k, input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input bit er, input logic [31:0] xd,
                      input string nm);
    bit got;
    got = 1'b0;
    @(negedge clk);
    drive(k, a, w, d, s);
    push(k, er, xd, cyc_cnt + 1 + WS[k], nm);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_a[k] || err_a[k]) begin
        got = 1'b1;
        break;
      end
    end
    release_bus(k);
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no response, want one within 40 cycles", nm);
    end
  endtask

  int base;
  int nack;

  initial begin
    for (int k = 0; k < NDut; k++) begin
      cyc_a[k] = 1'b0; stb_a[k] = 1'b0; we_a[k] = 1'b0;
      adr_a[k] = '0; dw_a[k] = '0; sel_a[k] = '0;
    end

    // Reset held for two rising edges.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NDut; k++) begin
      total++;
      if (ack_a[k] !== 1'b0 || err_a[k] !== 1'b0 || dr_a[k] !== 32'h0) begin
        bad++;
        $display("FAIL reset_state dut%0d: got ack=%0b err=%0b dat=%h, want 0 0 00000000",
                 k, ack_a[k], err_a[k], dr_a[k]);
      end
    end
    mon_en = 1'b1;

    // Zero wait states: reset contents, byte-lane writes, offset bits ignored.
    xfer(0, 32'h8, 1'b0, 32'h0, 4'hF, 1'b0, 32'hdeadbeef, "rd_after_reset");
    xfer(0, 32'h4, 1'b1, 32'h11223344, 4'hF, 1'b0, 32'h0, "wr_full");
    xfer(0, 32'h4, 1'b1, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0, "wr_sel5");
    xfer(0, 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, 32'h11BB33DD, "rd_merged");
    xfer(0, 32'h7, 1'b0, 32'h0, 4'h0, 1'b0, 32'h11BB33DD, "rd_offset_nosel");
    xfer(0, 32'h3C, 1'b1, 32'h0000A500, 4'h2, 1'b0, 32'h0, "wr_top_lane1");
    xfer(0, 32'h3C, 1'b0, 32'h0, 4'hF, 1'b0, 32'hdeada5ef, "rd_top");

    // Three wait states: single read, then STB held across three reads.
    xfer(1, 32'h0, 1'b0, 32'h0, 4'hF, 1'b0, 32'hdeadbeef, "ws3_rd");
    @(negedge clk);
    drive(1, 32'h0, 1'b0, 32'h0, 4'hF);
    base = cyc_cnt + 1;
    push(1, 1'b0, 32'hdeadbeef, base + 3, "burst_rd0");
    push(1, 1'b0, 32'hdeadbeef, base + 8, "burst_rd1");
    push(1, 1'b0, 32'hdeadbeef, base + 13, "burst_rd2");
    nack = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack_a[1]) nack++;
      if (nack == 3) break;
    end
    release_bus(1);
    if (nack != 3) begin
      total++;
      bad++;
      $display("FAIL burst_timeout: got %0d acks, want 3", nack);
    end

    // Window 0x100..0x13f.
    xfer(2, 32'h0FC, 1'b0, 32'h0, 4'hF, 1'b1, 32'hbadc0de0, "oor_rd_low");
    xfer(2, 32'h140, 1'b1, 32'h55555555, 4'hF, 1'b1, 32'hbadc0de0, "oor_wr_high");
    xfer(2, 32'h100, 1'b0, 32'h0, 4'hF, 1'b0, 32'hdeadbeef, "oor_no_corrupt");
    xfer(2, 32'h13C, 1'b1, 32'h01020304, 4'hF, 1'b0, 32'h0, "wr_win_top");
    xfer(2, 32'h13C, 1'b0, 32'h0, 4'hF, 1'b0, 32'h01020304, "rd_win_top");

    // Abort: CYC dropped two cycles into a four-wait-state write.
    @(negedge clk);
    drive(3, 32'h100, 1'b1, 32'h12345678, 4'hF);
    repeat (2) @(negedge clk);
    release_bus(3);
    repeat (8) @(negedge clk);
    xfer(3, 32'h100, 1'b0, 32'h0, 4'hF, 1'b0, 32'hdeadbeef, "abort_rd");

    // Reset during the first wait cycle, with CYC still held through the reset edge.
    @(negedge clk);
    drive(4, 32'h0, 1'b1, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    release_bus(4);
    repeat (6) @(negedge clk);
    xfer(4, 32'h0, 1'b0, 32'h0, 4'hF, 1'b0, 32'hdeadbeef, "rst_mid_rd");
    xfer(0, 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, 32'hdeadbeef, "rst_clears_mem");

    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s_missing: got no response, want ack=%0b err=%0b dat=%h cyc=%0d",
               e.name, !e.err, e.err, e.data, e.due);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
